// File: rtl/stream_fifo_sync.sv
// stream_fifo_sync: single-clock show-ahead FIFO for stream datapaths.
// A DEPTH x DATA_WIDTH RAM with a registered read port feeds a two-deep
// prefetch chain: a RAM read register (mid) and an output register (dout).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush               synchronous clear of contents (error flags kept)
//   wr_en, din          write request / data; full drops writes
//   rd_en, dout, empty  read acknowledge, head word, head-not-valid
//   level               words held (including the word on dout)
//   almostfull/empty    registered compares of level against af/ae_thresh
//   overflow/underflow  sticky error flags, cleared by err_clr
module stream_fifo_sync #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         wr_en,
  input  logic [DATA_WIDTH-1:0]        din,
  output logic                         full,
  output logic                         almostfull,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         empty,
  output logic                         almostempty,
  output logic [$clog2(DEPTH):0]       level,
  input  logic [$clog2(DEPTH):0]       af_thresh,
  input  logic [$clog2(DEPTH):0]       ae_thresh,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         err_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic [AW-1:0]         wptr, rptr;
  logic [AW:0]           ram_cnt, ram_cnt_nxt, level_nxt;
  logic                  mid_vld, out_vld;
  logic                  wr_acc, rd_acc, mid_mv, fetch;
  logic                  ovf_evt, udf_evt;

  // full and out_vld are registered, so acceptance uses pre-edge state.
  assign wr_acc  = wr_en && !full && !flush;
  assign rd_acc  = rd_en && out_vld && !flush;
  assign ovf_evt = wr_en && full && !flush;
  assign udf_evt = rd_en && !out_vld && !flush;

  // mid advances into the output stage when that stage is free or being read.
  assign mid_mv  = mid_vld && (!out_vld || rd_acc);
  // Only words written on earlier edges are fetched (ram_cnt is pre-edge),
  // so a fetch never reads the address being written this cycle.
  assign fetch   = (ram_cnt != '0) && (!mid_vld || mid_mv) && !flush;

  assign empty   = !out_vld;

  always_comb begin
    level_nxt = level;
    if (flush)                 level_nxt = '0;
    else if (wr_acc && !rd_acc) level_nxt = level + 1'b1;
    else if (rd_acc && !wr_acc) level_nxt = level - 1'b1;
  end

  always_comb begin
    ram_cnt_nxt = ram_cnt;
    if (wr_acc && !fetch)      ram_cnt_nxt = ram_cnt + 1'b1;
    else if (fetch && !wr_acc) ram_cnt_nxt = ram_cnt - 1'b1;
  end

  // Storage and registered read port; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= din;
    if (fetch)  ram_q     <= mem[rptr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr        <= '0;
      rptr        <= '0;
      ram_cnt     <= '0;
      mid_vld     <= 1'b0;
      out_vld     <= 1'b0;
      dout        <= '0;
      level       <= '0;
      full        <= 1'b0;
      almostfull  <= 1'b0;
      almostempty <= 1'b1;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      if (flush) begin
        wptr    <= '0;
        rptr    <= '0;
        ram_cnt <= '0;
        mid_vld <= 1'b0;
        out_vld <= 1'b0;
      end else begin
        if (wr_acc) wptr <= wptr + 1'b1;
        if (fetch)  rptr <= rptr + 1'b1;
        if (mid_mv) dout <= ram_q;
        ram_cnt <= ram_cnt_nxt;
        mid_vld <= fetch || (mid_vld && !mid_mv);
        out_vld <= mid_mv || (out_vld && !rd_acc);
      end
      level       <= level_nxt;
      full        <= (level_nxt == DEPTH_L);
      almostfull  <= (level_nxt >= af_thresh);
      almostempty <= (level_nxt <= ae_thresh);
      // A new error in the same cycle as err_clr keeps the flag set.
      overflow    <= ovf_evt || (overflow && !err_clr);
      underflow   <= udf_evt || (underflow && !err_clr);
    end
  end
endmodule

// File: tb/tb_stream_fifo_sync.sv
// Self-checking bench for stream_fifo_sync (DATA_WIDTH=128, DEPTH=512).
// Expected data comes from a queue filled on accepted writes; the head word
// is expected on dout once it has been stored for two edges.
module tb_stream_fifo_sync;
  localparam int DW = 128;
  localparam int DEPTH = 512;
  localparam int AW = 9;

  logic clk, rst, flush, wr_en, rd_en, err_clr;
  logic [DW-1:0] din, dout;
  logic full, almostfull, empty, almostempty, overflow, underflow;
  logic [AW:0] level, af_thr, ae_thr;

  stream_fifo_sync #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din),
    .full(full), .almostfull(almostfull), .rd_en(rd_en), .dout(dout),
    .empty(empty), .almostempty(almostempty), .level(level),
    .af_thresh(af_thr), .ae_thresh(ae_thr), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [DW-1:0] d; int wc; } ent_t;
  ent_t q[$];
  int   m_level, cyc, n_chk, n_fail;
  bit   m_ovf, m_udf;
  int   dcnt;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit mdl_empty();
    return (q.size() == 0) || (cyc - q[0].wc < 2);
  endfunction

  function automatic logic [DW-1:0] nd();
    dcnt++;
    return {$urandom, $urandom, $urandom, 32'(dcnt)};
  endfunction

  // One clock: called at posedge+1, drives inputs, predicts, checks at posedge+1.
  task automatic op(input logic w, input logic r, input logic [DW-1:0] d,
                    input logic fl = 1'b0, input logic ec = 1'b0);
    bit me, mf, wa, ra, oe, ue;
    wr_en = w; rd_en = r; din = d; flush = fl; err_clr = ec;
    me = mdl_empty();
    mf = (m_level == DEPTH);
    wa = w && !mf && !fl;
    ra = r && !me && !fl;
    oe = w && mf && !fl;
    ue = r && me && !fl;
    if (ra) chk("dout", dout, q[0].d);
    @(posedge clk);
    #1;
    cyc++;
    if (fl) begin
      q.delete();
      m_level = 0;
    end else begin
      if (ra) void'(q.pop_front());
      if (wa) q.push_back('{d: d, wc: cyc});
      m_level += int'(wa) - int'(ra);
    end
    m_ovf = oe || (m_ovf && !ec);
    m_udf = ue || (m_udf && !ec);
    chk("level", DW'(level), DW'(m_level));
    chk("full", DW'(full), DW'(m_level == DEPTH));
    chk("empty", DW'(empty), DW'(mdl_empty()));
    chk("almostfull", DW'(almostfull), DW'(m_level >= int'(af_thr)));
    chk("almostempty", DW'(almostempty), DW'(m_level <= int'(ae_thr)));
    chk("overflow", DW'(overflow), DW'(m_ovf));
    chk("underflow", DW'(underflow), DW'(m_udf));
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  task automatic fill_to(input int n);
    int g = 0;
    while (m_level < n) begin
      op(1'b1, 1'b0, nd());
      if (++g > 4*DEPTH) begin chk("fill_timeout", 1, 0); break; end
    end
  endtask

  task automatic drain_to(input int n);
    int g = 0;
    while (m_level > n) begin
      op(1'b0, !mdl_empty(), '0);
      if (++g > 4*DEPTH) begin chk("drain_timeout", 1, 0); break; end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"}, DW'(empty), 1);
    chk({tag, "_full"}, DW'(full), 0);
    chk({tag, "_af"}, DW'(almostfull), 0);
    chk({tag, "_ae"}, DW'(almostempty), 1);
    chk({tag, "_level"}, DW'(level), 0);
    chk({tag, "_ovf"}, DW'(overflow), 0);
    chk({tag, "_udf"}, DW'(underflow), 0);
    chk({tag, "_dout"}, dout, 0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; dcnt = -1; m_level = 0; m_ovf = 0; m_udf = 0;
    rst = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = '0;
    af_thr = 10'd256; ae_thr = 10'd16;
    #22;
    chk_reset_vals("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // Fill with incrementing words, then one write too many.
    for (int i = 0; i < DEPTH; i++) op(1'b1, 1'b0, DW'(i));
    chk("fill_full", DW'(full), 1);
    op(1'b1, 1'b0, DW'(32'hdead));
    chk("fill_ovf", DW'(overflow), 1);

    // Drain in order with rd_en held; the final read underflows.
    for (int i = 0; i <= DEPTH; i++) op(1'b0, 1'b1, '0);
    chk("drain_udf", DW'(underflow), 1);
    chk("drain_level", DW'(level), 0);
    op(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Random traffic with pointer wrap; model gates requests to avoid errors.
    for (int i = 0; i < 2000; i++)
      op(($urandom_range(0, 1) == 1) && (m_level < DEPTH),
         ($urandom_range(0, 1) == 1) && !mdl_empty(), nd());
    chk("rand_ovf", DW'(overflow), 0);
    chk("rand_udf", DW'(underflow), 0);

    // Simultaneous read/write at full, empty and mid level.
    fill_to(DEPTH);
    op(1'b1, 1'b1, nd());
    chk("sim_full_level", DW'(level), DEPTH - 1);
    drain_to(0);
    while (!mdl_empty()) op(1'b0, 1'b1, '0);
    op(1'b1, 1'b1, nd());
    chk("sim_empty_level", DW'(level), 1);
    fill_to(100);
    op(1'b1, 1'b1, nd());
    chk("sim_mid_level", DW'(level), 100);

    // Almost-empty threshold raised at level 40.
    drain_to(40);
    chk("ae_before", DW'(almostempty), 0);
    ae_thr = 10'd64;
    op(1'b0, 1'b0, '0);
    chk("ae_after", DW'(almostempty), 1);

    // Flush with a concurrent write; overflow is left set.
    fill_to(300);
    op(1'b1, 1'b0, nd(), 1'b1);
    chk("flush_level", DW'(level), 0);
    chk("flush_ovf", DW'(overflow), 1);

    // First-word latency into an empty FIFO.
    op(1'b1, 1'b0, nd());
    op(1'b0, 1'b0, '0);
    chk("lat_edge1", DW'(empty), 1);
    op(1'b0, 1'b0, '0);
    chk("lat_edge2", DW'(empty), 0);
    op(1'b0, 1'b1, '0);

    // err_clr together with a new underflow: underflow stays, overflow clears.
    op(1'b0, 1'b1, '0, 1'b0, 1'b1);
    chk("errclr_udf", DW'(underflow), 1);
    chk("errclr_ovf", DW'(overflow), 0);

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 20; i++) op(1'b1, !mdl_empty(), nd());
    wr_en = 1'b1; din = nd();
    #2 rst = 1'b0;
    #1 chk_reset_vals("midrst");
    wr_en = 1'b0;
    q.delete(); m_level = 0; m_ovf = 0; m_udf = 0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) op(1'b1, !mdl_empty(), nd());
    drain_to(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
